counter_up_down_mod: RTL

//  Parametrised synchronous up/down counter with modulo limit, parallel load,

---
 rtl/counter_up_down_mod.sv | 109 ++++++++++
 1 files changed

// File: rtl/counter_up_down_mod.sv
// ---------------------------------------------------------------------------
// counter_up_down_mod
//
// Parametrised synchronous up/down counter. It counts over the range
// 0..MAX_VAL and supports parallel load, a count enable, a synchronous clear,
// and a choice of wrap or saturate behaviour at the limits. A registered
// single-cycle pulse on tc_out flags each terminal-count event.
//
// Parameters
//   N        counter width in bits (N >= 2)
//   MAX_VAL  highest count value, 1..2**N-1
//
// Ports
//   clk          in   1  rising-edge clock
//   reset_al_in  in   1  asynchronous reset, active low
//   clear_in     in   1  synchronous clear to 0 (highest priority)
//   load_in      in   1  synchronous load of d_in, clamped to MAX_VAL
//   d_in         in   N  load value
//   en_in        in   1  count enable
//   up_down_in   in   1  1 = count up, 0 = count down
//   sat_in       in   1  1 = saturate at the limits, 0 = wrap modulo MAX_VAL+1
//   count_out    out  N  current count
//   tc_out       out  1  terminal-count pulse: an enabled step started at the
//                        limit in the current direction
//   ovf_out      out  1  sticky over/underflow flag; present only when
//                        COUNTER_UDM_STICKY_EN is defined
//
// Build option
//   COUNTER_UDM_STICKY_EN  adds ovf_out together with its flag register.
// ---------------------------------------------------------------------------
module counter_up_down_mod #(
    parameter int N       = 8,
    parameter int MAX_VAL = (2 ** N) - 1
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         clear_in,
    input  logic         load_in,
    input  logic [N-1:0] d_in,
    input  logic         en_in,
    input  logic         up_down_in,
    input  logic         sat_in,
`ifdef COUNTER_UDM_STICKY_EN
    output logic         ovf_out,
`endif
    output logic [N-1:0] count_out,
    output logic         tc_out
);

    // The limit is an explicit N-bit constant. Comparisons are made against
    // this constant rather than against the 2**N rollover, so the counter
    // also works when MAX_VAL is smaller than the full N-bit range.
    localparam logic [N-1:0] MAX_CNT = MAX_VAL[N-1:0];

    logic at_limit;
    logic step_at_limit;

    // The >= compare is only a guard. Loads are clamped, so the count never
    // actually goes above MAX_CNT.
    assign at_limit      = up_down_in ? (count_out >= MAX_CNT) : (count_out == '0);
    assign step_at_limit = en_in && at_limit;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            count_out <= '0;
            tc_out    <= 1'b0;
        end else if (clear_in) begin
            count_out <= '0;
            tc_out    <= 1'b0;
        end else if (load_in) begin
            count_out <= (d_in > MAX_CNT) ? MAX_CNT : d_in;
            tc_out    <= 1'b0;
        end else if (en_in) begin
            tc_out <= at_limit;
            if (up_down_in) begin
                if (at_limit)
                    count_out <= sat_in ? MAX_CNT : '0;
                else
                    count_out <= count_out + 1'b1;
            end else begin
                if (at_limit)
                    count_out <= sat_in ? '0 : MAX_CNT;
                else
                    count_out <= count_out - 1'b1;
            end
        end else begin
            tc_out <= 1'b0;
        end
    end

`ifdef COUNTER_UDM_STICKY_EN
    // The flag sets on the same edges that raise tc_out. A load does not
    // clear it; only clear_in or reset does.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in)
            ovf_out <= 1'b0;
        else if (clear_in)
            ovf_out <= 1'b0;
        else if (!load_in && step_at_limit)
            ovf_out <= 1'b1;
    end
`else
    // The flag is not built in this configuration. This assignment only keeps
    // step_at_limit from being reported as an unused signal.
    logic unused_step;
    assign unused_step = step_at_limit;
`endif

endmodule
